// File: rtl/rs_gf_pkg.sv
// rtl/rs_gf_pkg.sv - GF(256) constants, RS(16,8) generator and helpers shared by encoder and decoder
package rs_gf_pkg;

    localparam int SYM_BW = 8;
    localparam int N_NUM  = 16;
    localparam int K_NUM  = 8;
    localparam int R_NUM  = N_NUM - K_NUM;

    localparam logic [8:0] PRIM_POLY = 9'h11d;

    // g(x) = prod_{i=0..7}(x + a^i); index is the power of x, x^8 term (01) implicit
    localparam logic [7:0] RS_GEN [0:7] = '{
        8'h18, 8'hc8, 8'had, 8'hef, 8'h36, 8'h51, 8'h0b, 8'hff
    };

    typedef enum logic {
        DATA   = 1'b0,
        PARITY = 1'b1
    } enc_state_e;

    // Shift-and-add multiply; folds to a pure XOR network when one operand is constant
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = x[7] ? ((x << 1) ^ PRIM_POLY[7:0]) : (x << 1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_gf_cmul.sv
// rtl/rs_gf_cmul.sv - GF(256) multiply by a fixed coefficient
module rs_gf_cmul
    import rs_gf_pkg::*;
#(
    parameter logic [7:0] COEF = 8'h01
) (
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = gf_mul(a, COEF);

endmodule

// File: rtl/rs_enc_16_8.sv
// rtl/rs_enc_16_8.sv - systematic RS(16,8) encoder, data then parity (highest degree first)
module rs_enc_16_8
    import rs_gf_pkg::*;
#(
    parameter int SYM_BW = 8,
    parameter int N_NUM  = 16,
    parameter int K_NUM  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SYM_BW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SYM_BW-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop
);

    localparam int R_LEN = N_NUM - K_NUM;

    enc_state_e        state, state_d;
    logic [3:0]        sym_cnt, cnt_d;
    logic [SYM_BW-1:0] par_q [0:R_LEN-1];
    logic [SYM_BW-1:0] par_d [0:R_LEN-1];
    logic [SYM_BW-1:0] prod  [0:R_LEN-1];
    logic [SYM_BW-1:0] fb;
    logic [SYM_BW-1:0] data_d;
    logic              valid_d, sop_d, eop_d;
    logic              alive;
    logic              slot_free, accept;

    // alive keeps in_ready low while reset is asserted and for the first cycle after
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = alive && (state == DATA) && slot_free;
    assign accept    = in_valid && in_ready;
    assign fb        = in_data ^ par_q[R_LEN-1];

    for (genvar g = 0; g < R_LEN; g++) begin : g_cmul
        rs_gf_cmul #(
            .COEF (RS_GEN[g])
        ) u_cmul (
            .a (fb),
            .y (prod[g])
        );
    end

    always_comb begin
        state_d = state;
        cnt_d   = sym_cnt;
        par_d   = par_q;
        valid_d = out_valid;
        data_d  = out_data;
        sop_d   = out_sop;
        eop_d   = out_eop;

        if (slot_free) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end

        case (state)
            DATA: begin
                if (accept) begin
                    par_d[0] = prod[0];
                    for (int i = 1; i < R_LEN; i++) begin
                        par_d[i] = par_q[i-1] ^ prod[i];
                    end
                    data_d  = in_data;
                    valid_d = 1'b1;
                    sop_d   = (sym_cnt == 4'd0);
                    eop_d   = 1'b0;
                    if (sym_cnt == 4'(K_NUM - 1)) begin
                        state_d = PARITY;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = sym_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                // Shifting zeros in leaves P cleared after the last parity symbol
                if (slot_free) begin
                    data_d   = par_q[R_LEN-1];
                    par_d[0] = '0;
                    for (int i = 1; i < R_LEN; i++) begin
                        par_d[i] = par_q[i-1];
                    end
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = (sym_cnt == 4'(R_LEN - 1));
                    if (sym_cnt == 4'(R_LEN - 1)) begin
                        state_d = DATA;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = sym_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_d = DATA;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DATA;
            sym_cnt   <= 4'd0;
            for (int i = 0; i < R_LEN; i++) begin
                par_q[i] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            alive     <= 1'b0;
        end else begin
            state     <= state_d;
            sym_cnt   <= cnt_d;
            par_q     <= par_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_sop   <= sop_d;
            out_eop   <= eop_d;
            alive     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rs_enc_16_8.sv
// tb/tb_rs_enc_16_8.sv - scoreboard bench for rs_enc_16_8
module tb_rs_enc_16_8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;

    rs_enc_16_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       e;
    logic [7:0] rx_q [$];
    logic [7:0] gen [0:8];
    logic [7:0] g_exp [8] = '{8'hff, 8'h0b, 8'h51, 8'h36, 8'hef, 8'had, 8'hc8, 8'h18};
    logic [7:0] dv [8];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int ready_mode = 0;
    bit mon_en = 0;
    bit prev_stall = 0;
    bit in_parity = 0;
    int acc_cnt = 0;
    int run = 0;
    int max_run = 0;
    int n_sop = 0;
    int n_eop = 0;
    int sop_cyc = 0;
    int eop_cyc = 0;
    int acc_cyc = 0;
    int n_stall_chk = 0;
    logic [7:0] held_d;
    logic held_sop, held_eop;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 1) out_ready = ~out_ready;
        else                 out_ready = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Carry-less product then reduction by 0x11d
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'(9'h11d) << (k - 8));
        return p[7:0];
    endfunction

    function automatic void build_gen();
        logic [7:0] root;
        logic [7:0] nxt [0:8];
        for (int k = 0; k <= 8; k++) gen[k] = 8'h00;
        gen[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k <= 8; k++)
                nxt[k] = tb_gmul(gen[k], root) ^ ((k > 0) ? gen[k-1] : 8'h00);
            for (int k = 0; k <= 8; k++) gen[k] = nxt[k];
            root = tb_gmul(root, 8'h02);
        end
    endfunction

    // Codeword by long division of m(x)*x^8 by g(x); cw[0] is the x^15 coefficient
    function automatic void model_cw(input logic [7:0] d [8], output logic [7:0] cw [16]);
        logic [7:0] c [0:15];
        logic [7:0] q;
        for (int j = 0; j < 16; j++) c[j] = 8'h00;
        for (int j = 0; j < 8; j++) c[15-j] = d[j];
        for (int deg = 15; deg >= 8; deg--) begin
            q = c[deg];
            for (int k = 0; k <= 8; k++)
                c[deg-8+k] = c[deg-8+k] ^ tb_gmul(q, gen[k]);
        end
        for (int j = 0; j < 8; j++) cw[j] = d[j];
        for (int j = 0; j < 8; j++) cw[8+j] = c[7-j];
    endfunction

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            prev_stall = 0;
            in_parity  = 0;
            acc_cnt    = 0;
            run        = 0;
        end else begin
            if (prev_stall) begin
                n_total++;
                n_stall_chk++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_sop !== held_sop || out_eop !== held_eop)
                    $display("FAIL stall_hold: got v=%b d=%h sop=%b eop=%b, need v=1 d=%h sop=%b eop=%b",
                             out_valid, out_data, out_sop, out_eop, held_d, held_sop, held_eop);
                else
                    n_pass++;
            end
            if (out_valid && out_eop) in_parity = 0;
            if (in_parity) begin
                n_total++;
                if (in_ready !== 1'b0)
                    $display("FAIL parity_in_ready: got %b, need 0", in_ready);
                else
                    n_pass++;
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                if (acc_cnt % 8 == 0) in_parity = 1;
            end
            run = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                if (out_sop) begin n_sop++; sop_cyc = cyc; end
                if (out_eop) begin n_eop++; eop_cyc = cyc; end
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got d=%h with empty scoreboard, need no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop)
                        $display("FAIL sb_symbol: got d=%h sop=%b eop=%b, need d=%h sop=%b eop=%b",
                                 out_data, out_sop, out_eop, e.d, e.sop, e.eop);
                    else
                        n_pass++;
                end
            end
            prev_stall = out_valid && !out_ready;
            held_d   = out_data;
            held_sop = out_sop;
            held_eop = out_eop;
        end
    end

    task automatic send_cw(input logic [7:0] d [8], input int n_sym, input int gap_pct);
        logic [7:0] cw [16];
        exp_t x;
        int waited;
        bit done;
        model_cw(d, cw);
        for (int j = 0; j < 16; j++) begin
            x.d = cw[j];
            x.sop = (j == 0);
            x.eop = (j == 15);
            exp_q.push_back(x);
        end
        for (int i = 0; i < n_sym; i++) begin
            waited = 0;
            done = 0;
            while (!done) begin
                if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    in_data  = d[i];
                end
                @(negedge clk);
                done = in_valid && in_ready;
                if (done && i == 0) acc_cyc = cyc;
                @(posedge clk);
                #1;
                waited++;
                if (!done && waited > 100) begin
                    n_total++;
                    $display("FAIL accept_timeout: symbol %0d not accepted in %0d cycles, need acceptance", i, waited);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL drain_timeout: %0d symbols outstanding, need 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, need 0", out_valid); else n_pass++;
        n_total++;
        if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h, need 00", out_data); else n_pass++;
        n_total++;
        if (out_sop !== 1'b0) $display("FAIL rst_out_sop: got %b, need 0", out_sop); else n_pass++;
        n_total++;
        if (out_eop !== 1'b0) $display("FAIL rst_out_eop: got %b, need 0", out_eop); else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b, need 0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        for (int j = 0; j < 8; j++) dv[j] = 8'h00;
        rx_q.delete();
        max_run = 0;
        send_cw(dv, 8, 0);
        wait_drain();
        n_total++;
        if (sop_cyc - acc_cyc !== 1) $display("FAIL zero_latency: got %0d, need 1", sop_cyc - acc_cyc); else n_pass++;
        n_total++;
        if (eop_cyc - sop_cyc !== 15) $display("FAIL zero_sop_eop_span: got %0d, need 15", eop_cyc - sop_cyc); else n_pass++;
        n_total++;
        if (max_run !== 16) $display("FAIL zero_valid_run: got %0d, need 16", max_run); else n_pass++;
        n_total++;
        if (rx_q.size() !== 16) $display("FAIL zero_count: got %0d, need 16", rx_q.size());
        else begin
            n_pass++;
            for (int j = 0; j < 16; j++) begin
                n_total++;
                if (rx_q[j] !== 8'h00) $display("FAIL zero_sym%0d: got %h, need 00", j, rx_q[j]); else n_pass++;
            end
        end
    endtask

    task automatic test_unit(input int gap_pct, input int rmode);
        for (int j = 0; j < 8; j++) dv[j] = 8'h00;
        dv[7] = 8'h01;
        rx_q.delete();
        ready_mode = rmode;
        n_stall_chk = 0;
        send_cw(dv, 8, gap_pct);
        wait_drain();
        ready_mode = 0;
        n_total++;
        if (rx_q.size() !== 16) $display("FAIL unit_count: got %0d, need 16", rx_q.size());
        else begin
            n_pass++;
            for (int j = 0; j < 8; j++) begin
                n_total++;
                if (rx_q[8+j] !== g_exp[j]) $display("FAIL unit_par%0d: got %h, need %h", j, rx_q[8+j], g_exp[j]); else n_pass++;
            end
        end
        if (rmode == 1) begin
            n_total++;
            if (n_stall_chk == 0) $display("FAIL stall_seen: got 0 stalled cycles, need >0"); else n_pass++;
        end
    endtask

    task automatic test_linear();
        logic [7:0] s;
        logic [7:0] root;
        for (int j = 0; j < 8; j++) dv[j] = 8'h00;
        dv[7] = 8'h02;
        rx_q.delete();
        send_cw(dv, 8, 0);
        wait_drain();
        for (int j = 0; j < 8; j++) begin
            n_total++;
            if (rx_q[8+j] !== tb_gmul(8'h02, g_exp[j]))
                $display("FAIL linear_par%0d: got %h, need %h", j, rx_q[8+j], tb_gmul(8'h02, g_exp[j]));
            else n_pass++;
        end
        for (int j = 0; j < 8; j++) dv[j] = 8'($urandom);
        rx_q.delete();
        send_cw(dv, 8, 0);
        wait_drain();
        root = 8'h01;
        for (int i = 0; i < 8; i++) begin
            s = 8'h00;
            for (int j = 0; j < 16; j++) s = tb_gmul(s, root) ^ ((j < rx_q.size()) ? rx_q[j] : 8'h00);
            n_total++;
            if (s !== 8'h00) $display("FAIL syndrome_S%0d: got %h, need 00", i, s); else n_pass++;
            root = tb_gmul(root, 8'h02);
        end
    endtask

    task automatic test_reset_mid();
        int eop0, sop0;
        for (int j = 0; j < 8; j++) dv[j] = 8'($urandom);
        send_cw(dv, 5, 0);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b, need 0", out_valid); else n_pass++;
        n_total++;
        if (out_data !== 8'h00) $display("FAIL mid_rst_data: got %h, need 00", out_data); else n_pass++;
        n_total++;
        if (out_sop !== 1'b0 || out_eop !== 1'b0) $display("FAIL mid_rst_flags: got sop=%b eop=%b, need 0 0", out_sop, out_eop); else n_pass++;
        exp_q.delete();
        eop0 = n_eop;
        sop0 = n_sop;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 8; j++) dv[j] = 8'($urandom);
        rx_q.delete();
        send_cw(dv, 8, 0);
        wait_drain();
        n_total++;
        if (n_eop - eop0 !== 1) $display("FAIL mid_eop_count: got %0d, need 1", n_eop - eop0); else n_pass++;
        n_total++;
        if (n_sop - sop0 !== 1) $display("FAIL mid_sop_count: got %0d, need 1", n_sop - sop0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int eop0, sop0;
        eop0 = n_eop;
        sop0 = n_sop;
        max_run = 0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 8; j++) dv[j] = 8'($urandom);
            send_cw(dv, 8, 0);
        end
        wait_drain();
        n_total++;
        if (max_run !== 64) $display("FAIL b2b_valid_run: got %0d, need 64", max_run); else n_pass++;
        n_total++;
        if (n_sop - sop0 !== 4) $display("FAIL b2b_sop_count: got %0d, need 4", n_sop - sop0); else n_pass++;
        n_total++;
        if (n_eop - eop0 !== 4) $display("FAIL b2b_eop_count: got %0d, need 4", n_eop - eop0); else n_pass++;
    endtask

    initial begin
        build_gen();
        test_reset();
        test_zero();
        test_unit(0, 0);
        test_linear();
        test_unit(40, 1);
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
